rice_block_seq: RTL and testbench



---
 rtl/rice_pkg.sv | 9 +
 rtl/rice_block_seq_if.sv | 19 +
 rtl/rice_lzc.sv | 12 +
 rtl/rice_block_seq.sv | 95 +++++++++
 tb/tb_rice_block_seq.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/rice_pkg.sv
// rice_pkg: shared constants and state encoding for the Rice-decode sequencer
package rice_pkg;
  localparam int W = 32;
  localparam int KMAX = 27;
  localparam int FSMAX = 31;
  localparam int BUF_D = 64;
  localparam int CNT_W = 7;
  typedef enum logic [2:0] {IDLE, FS, SPLIT, EMIT, DONE, ERR} state_t;
endpackage

// File: rtl/rice_block_seq_if.sv
// rice_block_seq_if: compressed-word input stream and decoded-sample output stream
interface rice_block_seq_if;
  import rice_pkg::*;
  logic [W-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] out_sample;
  logic out_valid;
  logic out_ready;
  logic out_last;
  modport slave (
    input in_data, in_valid, out_ready,
    output in_ready, out_sample, out_valid, out_last
  );
  modport master (
    output in_data, in_valid, out_ready,
    input in_ready, out_sample, out_valid, out_last
  );
endinterface

// File: rtl/rice_lzc.sv
// rice_lzc: 32-bit leading-zero counter, count is 32 when the input is zero
module rice_lzc (
  input  logic [31:0] value,
  output logic [5:0] count,
  output logic zero
);
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) if (value[i]) count = 6'(31 - i);
  end
  assign zero = value == '0;
endmodule

// File: rtl/rice_block_seq.sv
// rice_block_seq: self-timed Rice codeword extractor emitting j samples per block
module rice_block_seq
  import rice_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [4:0] k,
  input  logic [4:0] j,
  output logic busy,
  output logic done,
  output logic err,
  rice_block_seq_if.slave bus
);
  state_t state;
  logic [BUF_D-1:0] bits, bits_next;
  logic [CNT_W-1:0] cnt, used, left;
  logic [4:0] k_q, j_q, idx, fs;
  logic [5:0] lz;
  logic zero, take, hit;
  logic [W-1:0] rem;
  rice_lzc u_lzc (.value(bits[63:32]), .count(lz), .zero(zero));
  assign bus.in_ready = cnt <= 7'd32;
  assign take = bus.in_valid && bus.in_ready;
  assign hit = !zero && {1'b0, lz} < cnt;
  assign rem = k_q == 5'd0 ? '0 : bits[63:32] >> (6'd32 - {1'b0, k_q});
  assign used = state == FS && hit ? CNT_W'(lz) + 7'd1 :
                state == SPLIT && cnt >= CNT_W'(k_q) ? CNT_W'(k_q) : '0;
  assign left = cnt - used;
  // incoming word lands directly below whatever survives this cycle's consume
  assign bits_next = (bits << used) | (take ? {bus.in_data, 32'b0} >> left : '0);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bits <= '0;
      cnt <= '0;
      k_q <= '0;
      j_q <= '0;
      idx <= '0;
      fs <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      bus.out_sample <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last <= 1'b0;
    end else begin
      bits <= bits_next;
      cnt <= left + (take ? 7'd32 : 7'd0);
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (k > 5'(KMAX)) err <= 1'b1;
          else begin
            k_q <= k;
            j_q <= j;
            err <= 1'b0;
            idx <= '0;
            busy <= 1'b1;
            state <= FS;
          end
        end
        FS: if (hit) begin
          fs <= lz[4:0];
          state <= SPLIT;
        end else if (cnt >= 7'd32) state <= ERR;
        SPLIT: if (cnt >= CNT_W'(k_q)) begin
          bus.out_sample <= (W'(fs) << k_q) | rem;
          bus.out_last <= idx == j_q - 5'd1;
          bus.out_valid <= 1'b1;
          state <= EMIT;
        end
        EMIT: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          if (bus.out_last) begin
            done <= 1'b1;
            busy <= 1'b0;
            state <= DONE;
          end else begin
            idx <= idx + 5'd1;
            state <= FS;
          end
        end
        DONE: state <= IDLE;
        ERR: begin
          err <= 1'b1;
          busy <= 1'b0;
          bits <= take ? {bus.in_data, 32'b0} : '0;
          cnt <= take ? 7'd32 : 7'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rice_block_seq.sv
// tb_rice_block_seq: directed vectors against hand-decoded Rice samples
module tb_rice_block_seq;
  import rice_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [4:0] k = '0, j = '0;
  logic busy, done, err;
  int n = 0, bad = 0, dones = 0;
  rice_block_seq_if bus ();
  rice_block_seq dut (.clk(clk), .reset(reset), .start(start), .k(k), .j(j),
                      .busy(busy), .done(done), .err(err), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (done) dones++;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    dones = 0;
  endtask
  task automatic push(input logic [31:0] w);
    bus.in_data = w;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !bus.in_ready; i++) step();
    check("push_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic go(input logic [4:0] kk, input logic [4:0] jj);
    k = kk;
    j = jj;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic expect_sample(input string tag, input logic [31:0] exp, input logic last);
    for (int i = 0; i < 40 && !bus.out_valid; i++) step();
    check({tag, "_valid"}, bus.out_valid, 1);
    check(tag, bus.out_sample, exp);
    check({tag, "_last"}, bus.out_last, last);
    step();
  endtask
  initial begin
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_sample", bus.out_sample, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    // basic block: 0101 100 00101 -> 5, 0, 9
    push(32'h5850_0000);
    check("c1_cnt_fill", dut.cnt, 32);
    go(2, 3);
    check("c1_busy", busy, 1);
    check("c1_lat_fs", bus.out_valid, 0);
    step();
    check("c1_lat_split", bus.out_valid, 0);
    step();
    check("c1_lat_emit", bus.out_valid, 1);
    expect_sample("c1_s0", 5, 0);
    expect_sample("c1_s1", 0, 0);
    expect_sample("c1_s2", 9, 1);
    check("c1_done", done, 1);
    check("c1_busy_low", busy, 0);
    check("c1_cnt_end", dut.cnt, 20);
    step();
    check("c1_done_pulse", done, 0);
    check("c1_dones", dones, 1);
    // fs=31 spans a whole word, split waits for the next word
    do_reset();
    push(32'h0000_0001);
    go(2, 1);
    step();
    check("c2_cnt_after_fs", dut.cnt, 0);
    step();
    step();
    check("c2_split_wait", bus.out_valid, 0);
    push(32'h4000_0000);
    expect_sample("c2_s0", 125, 1);
    check("c2_done", done, 1);
    // all-zero word with cnt 32 is an error
    do_reset();
    push(32'h0000_0000);
    go(0, 1);
    for (int i = 0; i < 20 && !err; i++) step();
    check("c3_err", err, 1);
    check("c3_busy", busy, 0);
    check("c3_cnt", dut.cnt, 0);
    check("c3_dones", dones, 0);
    push(32'h8000_0000);
    go(0, 1);
    check("c3_err_clr", err, 0);
    expect_sample("c3_s0", 0, 1);
    // illegal k leaves buffer untouched
    do_reset();
    push(32'h5850_0000);
    go(28, 3);
    check("c4_err", err, 1);
    check("c4_busy", busy, 0);
    check("c4_cnt", dut.cnt, 32);
    go(2, 3);
    check("c4_err_clr", err, 0);
    expect_sample("c4_s0", 5, 0);
    expect_sample("c4_s1", 0, 0);
    expect_sample("c4_s2", 9, 1);
    // backpressure on the second sample
    do_reset();
    push(32'h5850_0000);
    go(2, 3);
    expect_sample("c5_s0", 5, 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 40 && !bus.out_valid; i++) step();
    check("c5_cnt_stall", dut.cnt, 25);
    push(32'h0000_0000);
    check("c5_cnt_refill", dut.cnt, 57);
    for (int i = 0; i < 5; i++) begin
      check("c5_hold_valid", bus.out_valid, 1);
      check("c5_hold_sample", bus.out_sample, 0);
      step();
    end
    bus.out_ready = 1'b1;
    expect_sample("c5_s1", 0, 0);
    expect_sample("c5_s2", 9, 1);
    check("c5_cnt_end", dut.cnt, 52);
    // asynchronous reset mid-block
    do_reset();
    push(32'h5850_0000);
    go(2, 3);
    step();
    step();
    #1 reset = 1'b1;
    #1;
    check("c6_busy", busy, 0);
    check("c6_valid", bus.out_valid, 0);
    check("c6_sample", bus.out_sample, 0);
    check("c6_in_ready", bus.in_ready, 1);
    check("c6_cnt", dut.cnt, 0);
    step();
    step();
    reset = 1'b0;
    step();
    check("c6_no_done", dones, 0);
    push(32'h5850_0000);
    go(2, 3);
    expect_sample("c6_s0", 5, 0);
    expect_sample("c6_s1", 0, 0);
    expect_sample("c6_s2", 9, 1);
    check("c6_done", done, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
